// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared types and constants for the AXI read arbiter
package axi_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  localparam int         MASTER_NUM     = 2;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY      = 2'b00;

  // Slave-side ID carries the granted master index above the master ID.
  function automatic logic [7:0] tag_id(input logic idx, input logic [6:0] id, input int id_w);
    logic [7:0] r;
    r = {1'b0, id};
    r[id_w] = idx;
    return r;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// rtl/axi_rd_arbiter_if.sv - AXI read-path (AR + R) interface with master/slave views
interface axi_rd_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  // Issuer of read requests
  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  // Responder to read requests
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_rd_arbiter_rr.sv
// rtl/axi_rd_arbiter_rr.sv - two-request picker; AXI_RD_ARB_FIXED_PRIO_EN selects fixed M1 priority
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_idx
);

`ifdef AXI_RD_ARB_FIXED_PRIO_EN
  // Data side always wins a simultaneous request
  always_comb begin
    gnt_idx = req[1];
  end
`else
  // Single requester wins outright; a tie goes to whoever was not served last
  always_comb begin
    if (req == 2'b11) gnt_idx = ~last_grant;
    else              gnt_idx = req[1];
  end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-master AXI read arbiter; build option AXI_RD_ARB_FIXED_PRIO_EN
module axi_rd_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic     clk,
  input logic     rst,
  axi_rd_if.slave  m0,
  axi_rd_if.slave  m1,
  axi_rd_if.master s
);

  localparam logic [1:0] ST_IDLE = 2'(ARB_IDLE);
  localparam logic [1:0] ST_ADDR = 2'(ARB_ADDR);
  localparam logic [1:0] ST_DATA = 2'(ARB_DATA);

  logic [1:0] state;
  logic       grant;
  logic       last_grant;
  logic       pick;
  logic [1:0] req;

  assign req = {m1.arvalid, m0.arvalid};

  rr_arbiter2 u_pick (
    .req        (req),
    .last_grant (last_grant),
    .gnt_idx    (pick)
  );

  // Grant is captured in IDLE and held until the RLAST beat handshakes
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            grant <= pick;
            state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (s.arvalid && s.arready) state <= ST_DATA;
        end
        ST_DATA: begin
          if (s.rvalid && s.rready && s.rlast) begin
            last_grant <= grant;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // AR channel: steer the granted master to the slave only while in ADDR
  always_comb begin
    s.arvalid  = 1'b0;
    s.arid     = '0;
    s.araddr   = '0;
    s.arlen    = '0;
    s.arsize   = '0;
    s.arburst  = '0;
    m0.arready = 1'b0;
    m1.arready = 1'b0;
    if (state == ST_ADDR) begin
      if (grant) begin
        s.arvalid  = m1.arvalid;
        s.arid     = {1'b1, m1.arid};
        s.araddr   = m1.araddr;
        s.arlen    = m1.arlen;
        s.arsize   = m1.arsize;
        s.arburst  = m1.arburst;
        m1.arready = s.arready;
      end else begin
        s.arvalid  = m0.arvalid;
        s.arid     = {1'b0, m0.arid};
        s.araddr   = m0.araddr;
        s.arlen    = m0.arlen;
        s.arsize   = m0.arsize;
        s.arburst  = m0.arburst;
        m0.arready = s.arready;
      end
    end
  end

  // R channel: every beat in DATA goes to the granted master, whatever the tag bit says
  always_comb begin
    m0.rvalid = 1'b0;
    m0.rid    = '0;
    m0.rdata  = '0;
    m0.rresp  = RESP_OKAY;
    m0.rlast  = 1'b0;
    m1.rvalid = 1'b0;
    m1.rid    = '0;
    m1.rdata  = '0;
    m1.rresp  = RESP_OKAY;
    m1.rlast  = 1'b0;
    s.rready  = 1'b0;
    if (state == ST_DATA) begin
      if (grant) begin
        m1.rvalid = s.rvalid;
        m1.rid    = s.rid[ID_W-1:0];
        m1.rdata  = s.rdata;
        m1.rresp  = s.rresp;
        m1.rlast  = s.rlast;
        s.rready  = m1.rready;
      end else begin
        m0.rvalid = s.rvalid;
        m0.rid    = s.rid[ID_W-1:0];
        m0.rdata  = s.rdata;
        m0.rresp  = s.rresp;
        m0.rlast  = s.rlast;
        s.rready  = m0.rready;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - directed self-checking bench for axi_rd_arbiter
module tb_axi_rd_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  axi_rd_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) m0_if ();
  axi_rd_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) m1_if ();
  axi_rd_if #(.ID_W(5), .ADDR_W(32), .DATA_W(32)) s_if ();

  axi_rd_arbiter #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_if),
    .m1  (m1_if),
    .s   (s_if)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_if.arvalid = 0; m0_if.arid = 0; m0_if.araddr = 0; m0_if.arlen = 0;
    m0_if.arsize = 3'd2; m0_if.arburst = 2'b01; m0_if.rready = 1;
    m1_if.arvalid = 0; m1_if.arid = 0; m1_if.araddr = 0; m1_if.arlen = 0;
    m1_if.arsize = 3'd2; m1_if.arburst = 2'b01; m1_if.rready = 1;
    s_if.arready = 0; s_if.rvalid = 0; s_if.rid = 0; s_if.rdata = 0;
    s_if.rresp = 0; s_if.rlast = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  // Waits for an AR handshake, then returns a single-beat response
  task automatic serve(output logic [4:0] got_id, output bit ok);
    ok = 0;
    got_id = '0;
    s_if.arready = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (s_if.arvalid === 1'b1) begin
        ok = 1;
        got_id = s_if.arid;
        tick();
        break;
      end
      tick();
    end
    s_if.arready = 0;
    if (ok) begin
      s_if.rvalid = 1; s_if.rlast = 1; s_if.rid = got_id; s_if.rdata = 32'h1234_5678;
      tick();
      s_if.rvalid = 0; s_if.rlast = 0;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    m0_if.arvalid = 1;
    s_if.rvalid = 1;
    tick();
    tick();
    #1;
    n_cmp++;
    if ({s_if.arvalid, m0_if.arready, m1_if.arready, m0_if.rvalid, m1_if.rvalid, s_if.rready} !== 6'b0) begin
      n_bad++; $display("FAIL reset_handshakes: got %b want 000000",
        {s_if.arvalid, m0_if.arready, m1_if.arready, m0_if.rvalid, m1_if.rvalid, s_if.rready});
    end
    n_cmp++;
    if ({s_if.araddr, s_if.arid, m0_if.rdata} !== 69'h0) begin
      n_bad++; $display("FAIL reset_payload: got addr=%h id=%h rdata=%h want 0", s_if.araddr, s_if.arid, m0_if.rdata);
    end
    rst = 0;
    clear_inputs();
    tick();
  endtask

  task automatic test_single_m0();
    do_reset();
    m0_if.arvalid = 1; m0_if.araddr = 32'h0000_0010; m0_if.arid = 4'd3;
    s_if.arready = 1;
    #1;
    n_cmp++;
    if ({s_if.arvalid, m0_if.arready} !== 2'b00) begin
      n_bad++; $display("FAIL single_idle_latency: got arvalid/arready=%b want 00", {s_if.arvalid, m0_if.arready});
    end
    tick();
    #1;
    n_cmp++;
    if (s_if.arid !== 5'h03 || s_if.araddr !== 32'h10 || s_if.arvalid !== 1'b1) begin
      n_bad++; $display("FAIL single_s_ar: got id=%h addr=%h v=%b want 03 00000010 1", s_if.arid, s_if.araddr, s_if.arvalid);
    end
    n_cmp++;
    if ({m0_if.arready, m1_if.arready} !== 2'b10) begin
      n_bad++; $display("FAIL single_arready: got m0/m1=%b want 10", {m0_if.arready, m1_if.arready});
    end
    tick();
    m0_if.arvalid = 0; s_if.arready = 0;
    s_if.rvalid = 1; s_if.rlast = 1; s_if.rid = 5'h03; s_if.rdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if (m0_if.rvalid !== 1'b1 || m0_if.rdata !== 32'hDEAD_BEEF || m0_if.rid !== 4'd3 || m0_if.rlast !== 1'b1) begin
      n_bad++; $display("FAIL single_r: got v=%b data=%h id=%h last=%b want 1 deadbeef 3 1",
        m0_if.rvalid, m0_if.rdata, m0_if.rid, m0_if.rlast);
    end
    n_cmp++;
    if ({m1_if.rvalid, s_if.rready, m0_if.arready} !== 3'b010) begin
      n_bad++; $display("FAIL single_side: got m1v/srdy/m0ardy=%b want 010", {m1_if.rvalid, s_if.rready, m0_if.arready});
    end
    tick();
    s_if.rvalid = 0; s_if.rlast = 0;
    #1;
    n_cmp++;
    if ({m0_if.rvalid, s_if.rready} !== 2'b00) begin
      n_bad++; $display("FAIL single_done: got m0v/srdy=%b want 00", {m0_if.rvalid, s_if.rready});
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_arb_order();
    logic [4:0] got;
    logic [4:0] want;
    bit ok;
    logic [3:0] order;
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    order = 4'b1111;
`else
    order = 4'b1010;
`endif
    do_reset();
    m0_if.arvalid = 1; m0_if.arid = 4'h1; m0_if.araddr = 32'h100;
    m1_if.arvalid = 1; m1_if.arid = 4'h2; m1_if.araddr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      serve(got, ok);
      want = order[k] ? 5'h12 : 5'h01;
      n_cmp++;
      if (!ok || got !== want) begin
        n_bad++; $display("FAIL arb_order[%0d]: got arid=%h ok=%0d want %h", k, got, ok, want);
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_stall();
    logic [4:0] got;
    bit ok;
    do_reset();
    m0_if.arvalid = 1; m0_if.araddr = 32'h100; m0_if.arid = 4'h5;
    tick();
    m1_if.arvalid = 1; m1_if.araddr = 32'h600; m1_if.arid = 4'h6;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if ({s_if.araddr, s_if.arid, s_if.arvalid, m0_if.arready, m1_if.arready} !== {32'h100, 5'h05, 3'b100}) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got addr=%h id=%h v=%b rdy=%b%b want 00000100 05 1 00",
          i, s_if.araddr, s_if.arid, s_if.arvalid, m0_if.arready, m1_if.arready);
      end
      tick();
    end
    m0_if.arvalid = 0;
    #1;
    n_cmp++;
    if ({s_if.arvalid, m1_if.arready} !== 2'b00) begin
      n_bad++; $display("FAIL stall_drop: got s_arvalid/m1_arready=%b want 00", {s_if.arvalid, m1_if.arready});
    end
    tick();
    m0_if.arvalid = 1; s_if.arready = 1;
    #1;
    n_cmp++;
    if (s_if.arid !== 5'h05 || m0_if.arready !== 1'b1 || m1_if.arready !== 1'b0) begin
      n_bad++; $display("FAIL stall_resume: got id=%h m0rdy=%b m1rdy=%b want 05 1 0", s_if.arid, m0_if.arready, m1_if.arready);
    end
    tick();
    m0_if.arvalid = 0; s_if.arready = 0;
    s_if.rvalid = 1; s_if.rlast = 1; s_if.rid = 5'h05;
    tick();
    s_if.rvalid = 0; s_if.rlast = 0;
    serve(got, ok);
    m1_if.arvalid = 0;
    n_cmp++;
    if (!ok || got !== 5'h16) begin
      n_bad++; $display("FAIL stall_loser_next: got arid=%h ok=%0d want 16", got, ok);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_burst();
    do_reset();
    m1_if.arvalid = 1; m1_if.arid = 4'h7; m1_if.arlen = 4'd3; m1_if.araddr = 32'h400;
    s_if.arready = 1;
    tick();
    #1;
    n_cmp++;
    if (s_if.arlen !== 4'd3 || s_if.arid !== 5'h17 || s_if.arvalid !== 1'b1) begin
      n_bad++; $display("FAIL burst_ar: got len=%0d id=%h v=%b want 3 17 1", s_if.arlen, s_if.arid, s_if.arvalid);
    end
    tick();
    m1_if.arvalid = 0; s_if.arready = 0;
    m0_if.arvalid = 1; m0_if.arid = 4'h9; m0_if.araddr = 32'h900;
    for (int b = 0; b < 4; b++) begin
      s_if.rvalid = 1; s_if.rid = 5'h17; s_if.rdata = 32'h100 + b; s_if.rlast = (b == 3);
      #1;
      n_cmp++;
      if (m1_if.rvalid !== 1'b1 || m1_if.rdata !== 32'h100 + b || m0_if.rvalid !== 1'b0 || m0_if.arready !== 1'b0 || s_if.arvalid !== 1'b0) begin
        n_bad++; $display("FAIL burst_beat[%0d]: got m1v=%b data=%h m0v=%b m0ardy=%b sarv=%b want 1 %h 0 0 0",
          b, m1_if.rvalid, m1_if.rdata, m0_if.rvalid, m0_if.arready, s_if.arvalid, 32'h100 + b);
      end
      tick();
    end
    s_if.rvalid = 0; s_if.rlast = 0;
    #1;
    n_cmp++;
    if ({s_if.arvalid, m0_if.arready} !== 2'b00) begin
      n_bad++; $display("FAIL burst_idle_gap: got s_arvalid/m0_arready=%b want 00", {s_if.arvalid, m0_if.arready});
    end
    tick();
    #1;
    n_cmp++;
    if (s_if.arvalid !== 1'b1 || s_if.arid !== 5'h09) begin
      n_bad++; $display("FAIL burst_m0_grant: got v=%b id=%h want 1 09", s_if.arvalid, s_if.arid);
    end
    s_if.arready = 1;
    tick();
    m0_if.arvalid = 0; s_if.arready = 0;
    s_if.rvalid = 1; s_if.rlast = 1; s_if.rid = 5'h09;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    m0_if.arvalid = 1; m0_if.arid = 4'hA; s_if.arready = 1;
    tick();
    tick();
    m0_if.arvalid = 0; s_if.arready = 0; m0_if.rready = 0;
    s_if.rvalid = 1; s_if.rlast = 1; s_if.rdata = 32'hCAFE_0001; s_if.rid = 5'h1A;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({s_if.rready, m0_if.rvalid} !== 2'b01) begin
        n_bad++; $display("FAIL bp_stall[%0d]: got s_rready/m0_rvalid=%b want 01", i, {s_if.rready, m0_if.rvalid});
      end
      tick();
    end
    m0_if.rready = 1;
    #1;
    n_cmp++;
    if (s_if.rready !== 1'b1 || m0_if.rdata !== 32'hCAFE_0001 || m0_if.rid !== 4'hA) begin
      n_bad++; $display("FAIL bp_deliver: got rdy=%b data=%h id=%h want 1 cafe0001 a", s_if.rready, m0_if.rdata, m0_if.rid);
    end
    tick();
    s_if.rvalid = 0; s_if.rlast = 0;
    #1;
    n_cmp++;
    if ({m0_if.rvalid, s_if.rready} !== 2'b00) begin
      n_bad++; $display("FAIL bp_done: got m0v/srdy=%b want 00", {m0_if.rvalid, s_if.rready});
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [4:0] got;
    bit ok;
    do_reset();
    m0_if.arvalid = 1; m0_if.arid = 4'h2; s_if.arready = 1;
    tick();
    tick();
    m0_if.arvalid = 0; s_if.arready = 0;
    s_if.rvalid = 1; s_if.rlast = 0; s_if.rid = 5'h02; s_if.rdata = 32'h55;
    #1;
    n_cmp++;
    if (m0_if.rvalid !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_pre: got m0_rvalid=%b want 1", m0_if.rvalid);
    end
    rst = 1;
    tick();
    rst = 0;
    #1;
    n_cmp++;
    if ({s_if.arvalid, m0_if.arready, m1_if.arready, m0_if.rvalid, m1_if.rvalid, s_if.rready} !== 6'b0) begin
      n_bad++; $display("FAIL rstmid_outputs: got %b want 000000",
        {s_if.arvalid, m0_if.arready, m1_if.arready, m0_if.rvalid, m1_if.rvalid, s_if.rready});
    end
    s_if.rvalid = 0;
    m1_if.arvalid = 1; m1_if.arid = 4'h4;
    serve(got, ok);
    m1_if.arvalid = 0;
    n_cmp++;
    if (!ok || got !== 5'h14) begin
      n_bad++; $display("FAIL rstmid_regrant: got arid=%h ok=%0d want 14", got, ok);
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_m0();
    test_arb_order();
    test_stall();
    test_burst();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
